// File: rtl/fetch_unit_if.sv
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundles the signals around the instruction fetch stage.
//                These are the instruction memory request/response, the
//                execute-stage redirect, the decode stall, and the IF/ID
//                slot outputs.
//                The master modport is the fetch unit side.
//                The slave modport is the environment side (memory,
//                execute and decode).
//  Macro       : FETCH_MISALIGN_EN adds the fetch_fault signal.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Signals
//    imem_req      fetch -> mem   request, held high until imem_ack
//    imem_addr     fetch -> mem   64-bit request address
//    imem_ack      mem -> fetch   response strobe
//    imem_rdata    mem -> fetch   32-bit instruction word
//    branch_taken  exe -> fetch   redirect pulse
//    branch_target exe -> fetch   64-bit redirect PC
//    stall         dec -> fetch   decode does not consume the slot
//    if_valid      fetch -> dec   slot holds a valid instruction
//    if_instr      fetch -> dec   slot instruction word
//    if_opcode     fetch -> dec   if_instr[31:21]
//    if_pc         fetch -> dec   PC of if_instr
//    fetch_fault   fetch -> sys   misaligned redirect seen (macro only)
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [10:0] if_opcode;
    logic [63:0] if_pc;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_fault;
`endif

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  branch_taken,
        input  branch_target,
        input  stall,
        output if_valid,
        output if_instr,
        output if_opcode,
        output if_pc
`ifdef FETCH_MISALIGN_EN
        ,
        output fetch_fault
`endif
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output branch_taken,
        output branch_target,
        output stall,
        input  if_valid,
        input  if_instr,
        input  if_opcode,
        input  if_pc
`ifdef FETCH_MISALIGN_EN
        ,
        input  fetch_fault
`endif
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage.
//                Issues one request at a time to instruction memory and
//                fills a single IF/ID slot, with a one-entry buffer that
//                absorbs a response arriving while decode is stalled.
//                Redirects from execute take priority over every other
//                event.
//  Macro       : FETCH_MISALIGN_EN - a misaligned redirect enters a sticky
//                FAULT state and raises fetch_fault. Without the macro, the
//                low two target bits are forced to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Ports
//    clk     sole clock, rising edge
//    reset   synchronous active-high reset
//    bus     fetch_unit_if.master (memory, redirect, stall, IF/ID slot)
//  Parameters
//    RESET_PC  PC loaded on reset
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_unit_if.master      bus
);

`ifdef FETCH_MISALIGN_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_BUF   = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BUF   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;
`endif

    state_t      state_q;
    logic [63:0] pc_q;          // next address to fetch
    logic [63:0] req_addr_q;    // address of the request on the bus
    logic        imem_req_q;
    logic        if_valid_q;
    logic [31:0] if_instr_q;
    logic [63:0] if_pc_q;
    // The buffer is occupied exactly while the FSM sits in S_BUF.
    logic [31:0] buf_instr_q;
    logic [63:0] buf_pc_q;

    logic        w_slot_free;
    logic [63:0] w_pc_plus4;
    logic [63:0] w_target;
    logic        w_redirect;

    assign w_slot_free = !if_valid_q || !bus.stall;
    assign w_pc_plus4  = pc_q + 64'd4;     // wraps modulo 2^64

`ifdef FETCH_MISALIGN_EN
    logic fetch_fault_q;
    logic w_misaligned;

    assign w_target     = bus.branch_target;
    assign w_misaligned = |bus.branch_target[1:0];
    // A faulted unit ignores everything, including redirects.
    assign w_redirect   = bus.branch_taken && (state_q != S_FAULT);
`else
    assign w_target     = bus.branch_target & ~64'h3;
    assign w_redirect   = bus.branch_taken;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= 32'h0;
            if_pc_q     <= 64'h0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 64'h0;
`ifdef FETCH_MISALIGN_EN
            fetch_fault_q <= 1'b0;
`endif
        end else begin
            // The slot is consumed. A load further down overrides this.
            if (if_valid_q && !bus.stall) begin
                if_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    state_q    <= S_REQ;
                    req_addr_q <= pc_q;
                    imem_req_q <= 1'b1;
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        pc_q <= w_pc_plus4;
                        if (w_slot_free) begin
                            if_valid_q <= 1'b1;
                            if_instr_q <= bus.imem_rdata;
                            if_pc_q    <= req_addr_q;
                            req_addr_q <= w_pc_plus4;   // back-to-back
                        end else begin
                            buf_instr_q <= bus.imem_rdata;
                            buf_pc_q    <= req_addr_q;
                            state_q     <= S_BUF;
                            imem_req_q  <= 1'b0;
                        end
                    end
                end
                S_BUF: begin
                    if (!bus.stall) begin
                        if_valid_q <= 1'b1;
                        if_instr_q <= buf_instr_q;
                        if_pc_q    <= buf_pc_q;
                        state_q    <= S_REQ;
                        req_addr_q <= pc_q;
                        imem_req_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The stale response is dropped. Restart at the redirected pc.
                    if (bus.imem_ack) begin
                        state_q    <= S_REQ;
                        req_addr_q <= pc_q;
                    end
                end
                default: ;
            endcase

            // A redirect overrides everything above. It flushes the slot
            // and drops the buffer by leaving S_BUF.
            if (w_redirect) begin
                if_valid_q <= 1'b0;
                pc_q       <= w_target;
                imem_req_q <= 1'b1;
                if ((state_q == S_REQ || state_q == S_DRAIN) && !bus.imem_ack) begin
                    // The request is still outstanding. Keep it on the bus
                    // until its ack arrives, then discard the response.
                    state_q    <= S_DRAIN;
                    req_addr_q <= req_addr_q;
                end else begin
                    // Nothing is outstanding now. A same-cycle ack is
                    // discarded. Issue the new address directly.
                    state_q    <= S_REQ;
                    req_addr_q <= w_target;
                end
            end

`ifdef FETCH_MISALIGN_EN
            if (w_redirect && w_misaligned) begin
                state_q       <= S_FAULT;
                imem_req_q    <= 1'b0;
                if_valid_q    <= 1'b0;
                pc_q          <= pc_q;
                req_addr_q    <= req_addr_q;
                fetch_fault_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = req_addr_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_opcode = if_instr_q[31:21];
    assign bus.if_pc     = if_pc_q;
`ifdef FETCH_MISALIGN_EN
    assign bus.fetch_fault = fetch_fault_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//                Each accepted response is pushed to a queue together with
//                the PC it was fetched from.
//                The entry is popped and compared when decode consumes the
//                slot.
//                A redirect empties the queue, because it flushes the slot
//                and the buffer.
//  Macro       : FETCH_MISALIGN_EN selects the fault checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    int    total = 0;
    int    bad   = 0;
    exp_t  sb_q[$];

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs and score any slot consumption before the
    // edge. Return #1 after the edge.
    task automatic cyc(input logic ack, input logic [31:0] rdata, input logic st,
                       input logic br, input logic [63:0] tgt);
        exp_t e;
        bus.imem_ack      = ack;
        bus.imem_rdata    = rdata;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        if (br) begin
            sb_q.delete();
        end else if (bus.if_valid === 1'b1 && !st) begin
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=valid pc %h expected=no entry", bus.if_pc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_pc", bus.if_pc, e.pc);
                chk("sb_instr", {32'h0, bus.if_instr}, {32'h0, e.instr});
            end
        end
        @(posedge clk);
        #1;
        bus.imem_ack     = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 64'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_req",   {63'h0, bus.imem_req}, 64'h0);
        chk("rst_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("rst_instr", {32'h0, bus.if_instr}, 64'h0);
        chk("rst_pc",    bus.if_pc,     64'h0);
        chk("rst_addr",  bus.imem_addr, 64'h0);

        // IDLE -> REQ
        reset = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk("idle_req",  {63'h0, bus.imem_req}, 64'h1);
        chk("idle_addr", bus.imem_addr, 64'h0);

        // Streaming: ack every cycle, single-cycle latency
        push(64'h0, 32'h8B02_0020);
        cyc(1'b1, 32'h8B02_0020, 1'b0, 1'b0, 64'h0);
        chk("s0_valid",  {63'h0, bus.if_valid}, 64'h1);
        chk("s0_opcode", {53'h0, bus.if_opcode}, 64'h458);
        chk("s0_addr",   bus.imem_addr, 64'h4);
        push(64'h4, 32'h8B02_0020);
        cyc(1'b1, 32'h8B02_0020, 1'b0, 1'b0, 64'h0);
        chk("s1_pc", bus.if_pc, 64'h4);
        push(64'h8, 32'h8B02_0020);
        cyc(1'b1, 32'h8B02_0020, 1'b0, 1'b0, 64'h0);
        chk("s2_pc",   bus.if_pc, 64'h8);
        chk("s2_addr", bus.imem_addr, 64'hC);

        // Stall with the slot full: the response goes to the buffer
        push(64'hC, 32'hF840_0041);
        cyc(1'b1, 32'hF840_0041, 1'b1, 1'b0, 64'h0);
        chk("buf_req",   {63'h0, bus.imem_req}, 64'h0);
        chk("buf_instr", {32'h0, bus.if_instr}, 64'h8B02_0020);
        chk("buf_pc",    bus.if_pc, 64'h8);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        chk("buf_hold_req", {63'h0, bus.imem_req}, 64'h0);
        chk("buf_hold_pc",  bus.if_pc, 64'h8);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk("unbuf_instr", {32'h0, bus.if_instr}, 64'hF840_0041);
        chk("unbuf_req",   {63'h0, bus.imem_req}, 64'h1);
        chk("unbuf_addr",  bus.imem_addr, 64'h10);

        // Redirect without ack: drain the old request, then fetch at 0x100
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 64'h100);
        chk("dr_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("dr_req",   {63'h0, bus.imem_req}, 64'h1);
        chk("dr_addr",  bus.imem_addr, 64'h10);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk("dr_wait_addr", bus.imem_addr, 64'h10);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
        chk("dr_done_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("dr_done_addr",  bus.imem_addr, 64'h100);

        // Redirect and ack in the same cycle
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b1, 64'h200);
        chk("bra_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("bra_addr",  bus.imem_addr, 64'h200);
        push(64'h200, 32'hAAAA_5555);
        cyc(1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 64'h0);
        chk("bra_next_pc", bus.if_pc, 64'h200);

        // PC wrap at the top of the address space
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 64'h0);
        chk("wrap_addr0", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        push(64'hFFFF_FFFF_FFFF_FFFC, 32'h1111_2222);
        cyc(1'b1, 32'h1111_2222, 1'b0, 1'b0, 64'h0);
        chk("wrap_addr1", bus.imem_addr, 64'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

        // Misaligned redirect to 0x102
        cyc(1'b1, 32'h5555_AAAA, 1'b0, 1'b1, 64'h102);
`ifdef FETCH_MISALIGN_EN
        chk("mis_fault", {63'h0, bus.fetch_fault}, 64'h1);
        chk("mis_req",   {63'h0, bus.imem_req}, 64'h0);
        cyc(1'b1, 32'h5555_AAAA, 1'b0, 1'b1, 64'h300);
        chk("mis_hold_req",   {63'h0, bus.imem_req}, 64'h0);
        chk("mis_hold_valid", {63'h0, bus.if_valid}, 64'h0);
`else
        chk("mis_addr", bus.imem_addr, 64'h100);
        chk("mis_req",  {63'h0, bus.imem_req}, 64'h1);
`endif

        // Reset during an in-flight request; a late ack is ignored
        reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk("rr_req", {63'h0, bus.imem_req}, 64'h0);
`ifdef FETCH_MISALIGN_EN
        chk("rr_fault", {63'h0, bus.fetch_fault}, 64'h0);
`endif
        reset = 1'b0;
        cyc(1'b1, 32'h7777_7777, 1'b0, 1'b0, 64'h0);
        chk("rr_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("rr_addr",  bus.imem_addr, 64'h0);
        chk("rr_req2",  {63'h0, bus.imem_req}, 64'h1);

        chk("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction memory request; held high until imem_ack.
REQ-005 imem_addr  output  64  request address, from an internal registered req_addr; stable while imem_req=1.
REQ-006 imem_ack  input  1  response strobe; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 branch_taken  input  1  redirect pulse from the execute stage.
REQ-009 branch_target  input  64  redirect PC, sampled when branch_taken=1.
REQ-010 stall  input  1  downstream decode does not consume the IF/ID slot this cycle.
REQ-011 if_valid  output  1  IF/ID slot holds a valid instruction.
REQ-012 if_instr  output  32  IF/ID instruction word.
REQ-013 if_opcode  output  11  if_instr[31:21], combinational from the slot; drives the decode/control opcode input.
REQ-014 if_pc  output  64  PC of if_instr.
REQ-015 fetch_fault  output  1  misaligned redirect seen; exists only with FETCH_MISALIGN_EN.

Function
REQ-016 States SHALL be IDLE, REQ, BUF and DRAIN, plus FAULT with FETCH_MISALIGN_EN.
REQ-017 IDLE SHALL go to REQ unconditionally on the next cycle; imem_req=0 in IDLE.
REQ-018 On entry to REQ, req_addr SHALL load pc; imem_req=1 throughout REQ.
REQ-019 Slot free: if_valid=0, or if_valid=1 and stall=0.
REQ-020 REQ with imem_ack and slot free: slot SHALL load rdata/req_addr, if_valid=1 next cycle, pc+=4, and REQ SHALL re-issue back-to-back.
REQ-021 REQ with imem_ack and slot not free: rdata/req_addr go to a one-entry buffer, pc+=4, state BUF, imem_req=0.
REQ-022 In BUF with stall=0, the slot SHALL load from the buffer and the state SHALL return to REQ.
REQ-023 If the slot is consumed (if_valid=1, stall=0) and nothing loads it, if_valid SHALL clear next cycle.
REQ-024 While stall=1, slot contents SHALL hold unchanged.
REQ-025 branch_taken SHALL have priority over every other event: pc<=branch_target, if_valid<=0, buffer discarded.
REQ-026 Redirect in REQ without imem_ack: go to DRAIN; imem_req stays 1 at the old req_addr until ack; that response is discarded; then REQ at the new pc.
REQ-027 Redirect in REQ with imem_ack in the same cycle: response discarded, state REQ at branch_target.
REQ-028 Redirect in DRAIN SHALL update pc and remain in DRAIN; redirect in BUF or IDLE SHALL go to REQ.
REQ-029 pc arithmetic is 64-bit modulo: 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-030 Minimum latency SHALL be one cycle: ack in cycle N gives if_valid=1 in cycle N+1.

Reset
REQ-031 reset SHALL set state=IDLE, pc=RESET_PC, req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, buffer empty, fetch_fault=0.
REQ-032 reset SHALL override an in-flight request: imem_req=0 next cycle, and any later ack for that request SHALL be ignored.

Configuration
REQ-033 Macro FETCH_MISALIGN_EN defined: a redirect with branch_target[1:0]!=0 SHALL set fetch_fault=1, clear if_valid and enter FAULT; FAULT holds imem_req=0 and ignores all inputs until reset.
REQ-034 Macro FETCH_MISALIGN_EN undefined: branch_target[1:0] SHALL be forced to 2'b00; fetch_fault port and FAULT state absent.

Verification
REQ-035 Reset, RESET_PC=0, ack every cycle with rdata=32'h8B02_0020, stall=0 -> if_opcode=11'h458, if_pc=0,4,8 on consecutive cycles.
REQ-036 stall=1 with slot full, ack with rdata=32'hF840_0041 -> state BUF, imem_req=0, slot unchanged; release stall -> if_instr=32'hF840_0041 next cycle.
REQ-037 branch_taken with target 64'h100 during REQ without ack, ack 3 cycles later -> that data discarded, next imem_addr=64'h100, if_valid=0 meanwhile.
REQ-038 branch_taken and imem_ack in the same cycle -> no slot load, next imem_addr=branch_target.
REQ-039 pc=64'hFFFF_FFFF_FFFF_FFFC, ack -> next imem_addr=0.
REQ-040 Macro FETCH_MISALIGN_EN: redirect to 64'h102 -> fetch_fault=1, imem_req=0 held; reset -> fetch_fault=0; without macro, next imem_addr=64'h100.
